// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: debounced lines, 11-bit frame decode with odd
// parity and idle timeout, feeding a small byte FIFO with error/overflow pulses.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH      = 8,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int TIMEOUT_CYCLES  = 100000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          io_kclk,
    input  logic                          io_kdata,
    input  logic                          io_out_ready,
    output logic                          io_out_valid,
    output logic [7:0]                    io_out_bits,
    output logic [$clog2(FIFO_DEPTH):0]   io_count,
    output logic                          io_parity_err,
    output logic                          io_frame_err,
    output logic                          io_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   FULL    = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
        return (v == DB_MAX) ? v : v + DW'(1);
    endfunction

    // Stage p0/p1: raw lines and their previous-cycle copy; filtered lines.
    logic [1:0]    raw_p0;
    logic [1:0]    raw_p1;
    logic [1:0]    flt_p1;
    logic [DW-1:0] db_cnt [2];

    assign raw_p0 = {io_kdata, io_kclk};

    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                raw_p1[i] <= 1'b1;
                flt_p1[i] <= 1'b1;
                db_cnt[i] <= '0;
            end else begin
                raw_p1[i] <= raw_p0[i];
                if (raw_p0[i] != raw_p1[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= sat_inc(db_cnt[i]);
                    if (sat_inc(db_cnt[i]) == DB_MAX)
                        flt_p1[i] <= raw_p0[i];
                end
            end
        end
    end

    // Stage p2: falling-edge detect on filtered kclk, frame FSM and timeout.
    logic          kclk_flt_p2;
    logic          kdata_flt;
    logic          fall;
    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] idle_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          frame_done;
    logic          stop_bad;
    logic          par_bad;
    logic          timeout;
    logic          push_req;
    logic          push_ok;
    logic          pop;

    assign kdata_flt  = flt_p1[1];
    assign fall       = kclk_flt_p2 & ~flt_p1[0];
    assign frame_done = fall && (state == STOP);
    assign stop_bad   = ~kdata_flt;
    assign par_bad    = ~^{shreg, par_bit};
    assign push_req   = frame_done & ~stop_bad & ~par_bad;
    assign timeout    = (state != IDLE) && !fall && (idle_cnt == TO_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            kclk_flt_p2   <= 1'b1;
            state         <= IDLE;
            bit_cnt       <= '0;
            idle_cnt      <= '0;
            io_parity_err <= 1'b0;
            io_frame_err  <= 1'b0;
            io_overflow   <= 1'b0;
        end else begin
            kclk_flt_p2   <= flt_p1[0];
            io_parity_err <= frame_done & ~stop_bad & par_bad;
            io_frame_err  <= (frame_done & stop_bad) | timeout;
            io_overflow   <= push_req & ~push_ok;
            if ((state == IDLE) || fall || timeout)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + TW'(1);
            if (timeout) begin
                state <= IDLE;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!kdata_flt) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY:  state <= STOP;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (fall && (state == DATA))
            shreg <= {kdata_flt, shreg[7:1]};
        if (fall && (state == PARITY))
            par_bit <= kdata_flt;
    end

    // Stage p3: receive FIFO; a pop in the same cycle frees the slot for a push.
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;

    assign pop          = (count != '0) & io_out_ready;
    assign push_ok      = push_req & ((count != FULL) | pop);
    assign io_out_valid = (count != '0);
    assign io_out_bits  = mem[rptr];
    assign io_count     = count;

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok)
            mem[wptr] <= shreg;
    end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: table-driven frames, directed corner sequences and
// randomized frames checked against a byte-queue model of the receiver.
module tb_ps2_rx_fifo;
    localparam int DEPTH = 4;
    localparam int DB    = 2;
    localparam int TO    = 200;
    localparam int HALF  = 20;
    // Raw edge -> filtered change takes DB+1 clocks, the FSM acts one clock later.
    localparam int LAT   = DB + 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       kclk  = 1'b1;
    logic       kdata = 1'b1;
    logic       ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_bits;
    logic [2:0] count;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    ps2_rx_fifo #(
        .FIFO_DEPTH     (DEPTH),
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_kclk      (kclk),
        .io_kdata     (kdata),
        .io_out_ready (ready),
        .io_out_valid (out_valid),
        .io_out_bits  (out_bits),
        .io_count     (count),
        .io_parity_err(parity_err),
        .io_frame_err (frame_err),
        .io_overflow  (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] b;
        logic       pflip;
        logic       stopv;
        logic       ep;
        logic       ef;
        logic       epush;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int par_cyc = 0;
    int frm_cyc = 0;
    int ovf_cyc = 0;
    int ready_mode = 0;
    logic [7:0] q[$];
    logic [7:0] popped[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Consumer side: occupancy, head byte and pop order against the model.
    always @(negedge clock) begin
        if (parity_err === 1'b1) par_cyc++;
        if (frame_err === 1'b1) frm_cyc++;
        if (overflow === 1'b1) ovf_cyc++;
        if (!reset) begin
            check("mon count", 32'(count), q.size());
            check("mon valid", 32'(out_valid), 32'(q.size() != 0));
            if (out_valid && ready && q.size() != 0) begin
                check("mon head", 32'(out_bits), 32'(q[0]));
                popped.push_back(q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       ready = 1'b0;
                1:       ready = 1'b1;
                default: ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic drive_bit(input logic v);
        kdata = v;
        wait_cyc(HALF / 2);
        kclk = 1'b0;
        wait_cyc(HALF);
        kclk = 1'b1;
        wait_cyc(HALF / 2);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic pflip, input logic stopv,
                              input logic ep, input logic ef, input logic epush,
                              input string name);
        logic [10:0] bits;
        logic        exp_ovf;
        int          p0, f0, o0;
        bits = {stopv, (~^b) ^ pflip, b, 1'b0};
        p0 = par_cyc;
        f0 = frm_cyc;
        o0 = ovf_cyc;
        for (int i = 0; i < 10; i++)
            drive_bit(bits[i]);
        kdata = bits[10];
        wait_cyc(HALF / 2);
        kclk = 1'b0;
        wait_cyc(LAT);
        exp_ovf = epush && (q.size() >= DEPTH);
        if (epush && !exp_ovf)
            q.push_back(b);
        check({name, " parity_err"}, 32'(parity_err), 32'(ep));
        check({name, " frame_err"}, 32'(frame_err), 32'(ef));
        check({name, " overflow"}, 32'(overflow), 32'(exp_ovf));
        check({name, " count"}, 32'(count), q.size());
        check({name, " valid"}, 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0)
            check({name, " head"}, 32'(out_bits), 32'(q[0]));
        wait_cyc(HALF - LAT);
        kclk = 1'b1;
        wait_cyc(HALF / 2);
        kdata = 1'b1;
        wait_cyc(HALF / 2);
        check({name, " parity pulses"}, par_cyc - p0, 32'(ep));
        check({name, " frame pulses"}, frm_cyc - f0, 32'(ef));
        check({name, " overflow pulses"}, ovf_cyc - o0, 32'(exp_ovf));
    endtask

    initial begin
        vec_t       tbl[6];
        logic [7:0] order[4];
        int         p0, f0, o0, k;
        logic [7:0] rb;

        tbl[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{8'h1C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        order  = '{8'h11, 8'h22, 8'h33, 8'h44};

        wait_cyc(3);
        check("reset count", 32'(count), 0);
        check("reset valid", 32'(out_valid), 0);
        check("reset parity_err", 32'(parity_err), 0);
        check("reset frame_err", 32'(frame_err), 0);
        check("reset overflow", 32'(overflow), 0);
        reset = 1'b0;
        wait_cyc(5);

        ready_mode = 1;
        for (int i = 0; i < 6; i++)
            send_frame(tbl[i].b, tbl[i].pflip, tbl[i].stopv, tbl[i].ep, tbl[i].ef,
                       tbl[i].epush, $sformatf("vec%0d", i));

        ready_mode = 0;
        wait_cyc(2);
        o0 = ovf_cyc;
        for (int i = 0; i < 5; i++)
            send_frame(8'h11 * 8'(i + 1), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                       $sformatf("fill%0d", i));
        check("full count", 32'(count), DEPTH);
        check("overflow total", ovf_cyc - o0, 1);
        popped.delete();
        ready_mode = 1;
        wait_cyc(10);
        check("drained count", popped.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < popped.size())
                check($sformatf("pop order %0d", i), 32'(popped[i]), 32'(order[i]));
        check("drained valid", 32'(out_valid), 0);

        p0 = par_cyc;
        f0 = frm_cyc;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        kdata = 1'b1;
        wait_cyc(HALF / 2);
        kclk = 1'b0;
        for (k = 1; k <= LAT + TO; k++) begin
            wait_cyc(1);
            if (k == HALF) kclk = 1'b1;
            if (k == LAT + TO - 1) check("timeout early", 32'(frame_err), 0);
        end
        check("timeout pulse", 32'(frame_err), 1);
        wait_cyc(5);
        check("timeout frame pulses", frm_cyc - f0, 1);
        check("timeout parity pulses", par_cyc - p0, 0);
        check("timeout count", 32'(count), 0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "after timeout");

        p0 = par_cyc;
        f0 = frm_cyc;
        kclk = 1'b0;
        wait_cyc(1);
        kclk = 1'b1;
        wait_cyc(30);
        check("glitch frame pulses", frm_cyc - f0, 0);
        check("glitch parity pulses", par_cyc - p0, 0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "after glitch");
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "bad stop");

        ready_mode = 0;
        wait_cyc(2);
        send_frame(8'h12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "pre-reset a");
        send_frame(8'h34, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "pre-reset b");
        drive_bit(1'b0);
        for (int i = 0; i < 5; i++)
            drive_bit(1'b1);
        p0 = par_cyc;
        f0 = frm_cyc;
        o0 = ovf_cyc;
        reset = 1'b1;
        q.delete();
        wait_cyc(3);
        check("midreset count", 32'(count), 0);
        check("midreset valid", 32'(out_valid), 0);
        reset = 1'b0;
        wait_cyc(TO + 50);
        check("midreset pulses", (par_cyc - p0) + (frm_cyc - f0) + (ovf_cyc - o0), 0);
        ready_mode = 1;
        send_frame(8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "after reset");

        for (int i = 0; i < 24; i++) begin
            ready_mode = ($urandom_range(0, 2) == 0) ? 0 : 2;
            rb = 8'($urandom);
            k = $urandom_range(0, 9);
            if (k < 7)
                send_frame(rb, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, $sformatf("rnd%0d good", i));
            else if (k < 9)
                send_frame(rb, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, $sformatf("rnd%0d parity", i));
            else
                send_frame(rb, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1, 1'b0,
                           $sformatf("rnd%0d stop", i));
        end
        ready_mode = 1;
        wait_cyc(20);
        check("final count", 32'(count), 0);
        check("final valid", 32'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
